sipo_framer: RTL and testbench

//   Upstream feeder for the 8-bit parallel register stage. Assembles framed serial

---
 rtl/regs_pkg.sv | 11 +
 rtl/bit_counter.sv | 52 +++++
 rtl/sipo_framer.sv | 145 ++++++++++++++
 tb/tb_sipo_framer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/regs_pkg.sv
// Shared constants for the serial-to-parallel framer and the register stage it feeds.
package regs_pkg;

  // Framer FSM state encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Word width of the downstream parallel register stage.
  localparam int REG_W = 8;

endpackage : regs_pkg

// File: rtl/bit_counter.sv
// Modulo-MOD bit counter. The sync clear is applied first and the enable second,
// so clr and en together leave the counter at 1 (the first bit of a new frame).
// A count of MOD-1 plus an enable wraps to 0.
module bit_counter #(
  parameter  int MOD = 8,
  localparam int CW  = $clog2(MOD + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] LAST_C = CW'(MOD - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] base_s;
  logic [CW-1:0] next_s;

  // Next-count computation: optional clear, then optional increment with wrap.
  always_comb begin
    base_s = '0;
    next_s = '0;
    if (clr) begin
      base_s = '0;
    end else begin
      base_s = count_r;
    end
    if (en) begin
      if (base_s == LAST_C) begin
        next_s = '0;
      end else begin
        next_s = base_s + CW'(1);
      end
    end else begin
      next_s = base_s;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      count_r <= next_s;
    end
  end

  assign count = count_r;

endmodule : bit_counter

// File: rtl/sipo_framer.sv
// Serial-to-parallel framer: collects framed serial bits into a WIDTH-bit word
// and offers it on a valid/ready port through a separate holding register, so
// the next frame can shift in while the current word waits for the consumer.
module sipo_framer #(
  parameter int WIDTH     = regs_pkg::REG_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       frame_start,
  input  logic                       out_ready,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun,
  output logic                       frame_err
);

  import regs_pkg::*;

  localparam int              CW     = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_C = CW'(WIDTH - 1);

  logic [0:0]       state_r;
  logic [0:0]       state_next_s;
  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] sr_base_s;
  logic [WIDTH-1:0] shifted_s;
  logic             start_s;
  logic             accept_s;
  logic             restart_s;
  logic             complete_s;
  logic             load_s;
  logic             drop_s;
  logic             xfer_s;

  // A frame_start bit always begins a new frame; in SHIFT it also aborts the old one.
  assign start_s    = bit_valid & frame_start;
  assign accept_s   = start_s | (bit_valid & (state_r == ST_SHIFT));
  assign restart_s  = start_s & (state_r == ST_SHIFT);
  assign complete_s = bit_valid & ~frame_start & (state_r == ST_SHIFT) & (bit_count == LAST_C);
  assign xfer_s     = out_valid & out_ready;
  assign load_s     = complete_s & (~out_valid | out_ready);
  assign drop_s     = complete_s & out_valid & ~out_ready;
  assign busy       = (state_r == ST_SHIFT);

  bit_counter #(.MOD(WIDTH)) u_bit_counter (
    .clk   (clk),
    .rst_n (rst),
    .en    (accept_s),
    .clr   (start_s),
    .count (bit_count)
  );

  // Shift-register next value; a new frame starts from an empty register.
  always_comb begin
    sr_base_s = '0;
    shifted_s = '0;
    if (start_s) begin
      sr_base_s = '0;
    end else begin
      sr_base_s = sr_r;
    end
    if (MSB_FIRST) begin
      shifted_s = {sr_base_s[WIDTH-2:0], serial_in};
    end else begin
      shifted_s = {serial_in, sr_base_s[WIDTH-1:1]};
    end
  end

  // Shift register: advances on every accepted bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_r <= '0;
    end else if (accept_s) begin
      sr_r <= shifted_s;
    end else begin
      sr_r <= sr_r;
    end
  end

  // FSM next-state: enter SHIFT on a frame start, return to IDLE on completion.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (complete_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Output holding register: load a finished word if the slot is free or being freed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
    end else if (load_s) begin
      parallel_out <= shifted_s;
      out_valid    <= 1'b1;
    end else if (xfer_s) begin
      parallel_out <= parallel_out;
      out_valid    <= 1'b0;
    end else begin
      parallel_out <= parallel_out;
      out_valid    <= out_valid;
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= (clr_err ? 1'b0 : overrun)   | drop_s;
      frame_err <= (clr_err ? 1'b0 : frame_err) | restart_s;
    end
  end

endmodule : sipo_framer

// File: tb/tb_sipo_framer.sv
// Self-checking bench for sipo_framer: one MSB-first and one LSB-first instance
// share the same stimulus and are compared every cycle against a frame-level model.
module tb_sipo_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in, bit_valid, frame_start, out_ready, clr_err;

  logic [7:0] pout_m, pout_l;
  logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l, ferr_m, ferr_l;
  logic [3:0] cnt_m, cnt_l;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: bits of the frame in progress plus the held word and flags.
  bit         fq[$];
  logic [7:0] mw_m, mw_l;
  logic       mv, mo, mf;
  logic       rdy_g;

  always #5 clk = ~clk;

  sipo_framer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clr_err(clr_err),
    .parallel_out(pout_m), .out_valid(valid_m), .busy(busy_m),
    .bit_count(cnt_m), .overrun(ovr_m), .frame_err(ferr_m)
  );

  sipo_framer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .serial_in(serial_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .out_ready(out_ready), .clr_err(clr_err),
    .parallel_out(pout_l), .out_valid(valid_l), .busy(busy_l),
    .bit_count(cnt_l), .overrun(ovr_l), .frame_err(ferr_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    mw_m = 8'h00; mw_l = 8'h00; mv = 1'b0; mo = 1'b0; mf = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using the pre-edge inputs.
  task automatic model_edge(input logic sv, bv, fs, rdy, ce);
    logic       comp, drop, fev;
    logic [7:0] nm, nl;
    comp = 1'b0; drop = 1'b0; fev = 1'b0; nm = 8'h00; nl = 8'h00;
    if (bv) begin
      if (fs) begin
        if (fq.size() > 0) fev = 1'b1;
        fq.delete();
        fq.push_back(sv);
      end else if (fq.size() > 0) begin
        fq.push_back(sv);
        if (fq.size() == 8) begin
          comp = 1'b1;
          for (int i = 0; i < 8; i++) begin
            nm[7-i] = fq[i];
            nl[i]   = fq[i];
          end
          fq.delete();
        end
      end
    end
    if (comp && (!mv || rdy)) begin
      mw_m = nm; mw_l = nl; mv = 1'b1;
    end else if (comp) begin
      drop = 1'b1;
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
    mo = (ce ? 1'b0 : mo) | drop;
    mf = (ce ? 1'b0 : mf) | fev;
  endtask

  task automatic check_all();
    chk("m_pout",  32'(pout_m),  32'(mw_m));
    chk("m_valid", 32'(valid_m), 32'(mv));
    chk("m_busy",  32'(busy_m),  32'(fq.size() > 0));
    chk("m_count", 32'(cnt_m),   32'(fq.size()));
    chk("m_ovr",   32'(ovr_m),   32'(mo));
    chk("m_ferr",  32'(ferr_m),  32'(mf));
    chk("l_pout",  32'(pout_l),  32'(mw_l));
    chk("l_valid", 32'(valid_l), 32'(mv));
    chk("l_busy",  32'(busy_l),  32'(fq.size() > 0));
    chk("l_count", 32'(cnt_l),   32'(fq.size()));
    chk("l_ovr",   32'(ovr_l),   32'(mo));
    chk("l_ferr",  32'(ferr_l),  32'(mf));
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check 1 time unit later.
  task automatic cyc(input logic sv, bv, fs, rdy, ce);
    serial_in = sv; bit_valid = bv; frame_start = fs; out_ready = rdy; clr_err = ce;
    @(posedge clk);
    model_edge(sv, bv, fs, rdy, ce);
    #1;
    check_all();
  endtask

  // Send the top n bits of w, first bit = w[7], frame_start on the first bit.
  task automatic send_bits(input logic [7:0] w, input int n, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) cyc(1'b0, 1'b0, 1'b0, rdy_g, 1'b0);
      end
      cyc(w[7-i], 1'b1, (i == 0), rdy_g, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b0; serial_in = 1'b0; bit_valid = 1'b0; frame_start = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0; rdy_g = 1'b1;
    model_reset();
    @(posedge clk); #1; check_all();
    #2 rst = 1'b1;

    // Pattern A5 with ready high: valid for exactly one cycle.
    rdy_g = 1'b1;
    send_bits(8'hA5, 8, -1, 0);
    chk("t1_msb_a5", 32'(pout_m), 32'h0000_00A5);
    chk("t1_lsb_a5", 32'(pout_l), 32'h0000_00A5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_valid_pulse", 32'(valid_m), 32'h0000_0000);

    // Stream 0000_0001: the LSB-first instance reverses it.
    send_bits(8'h01, 8, -1, 0);
    chk("t2_lsb_80", 32'(pout_l), 32'h0000_0080);
    chk("t2_msb_01", 32'(pout_m), 32'h0000_0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Consumer stalled: second word is dropped and overrun is flagged.
    rdy_g = 1'b0;
    send_bits(8'h3C, 8, -1, 0);
    send_bits(8'hC3, 8, -1, 0);
    chk("t3_hold_3c", 32'(pout_m), 32'h0000_003C);
    chk("t3_overrun", 32'(ovr_m),  32'h0000_0001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_clr",     32'(ovr_m),  32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Aborted frame followed by a full 5A frame.
    rdy_g = 1'b1;
    send_bits(8'hE0, 3, -1, 0);
    chk("t4_cnt3", 32'(cnt_m), 32'h0000_0003);
    send_bits(8'h5A, 8, -1, 0);
    chk("t4_ferr", 32'(ferr_m), 32'h0000_0001);
    chk("t4_5a",   32'(pout_m), 32'h0000_005A);
    chk("t4_cnt0", 32'(cnt_m),  32'h0000_0000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Five idle cycles mid-frame.
    send_bits(8'hFF, 8, 4, 5);
    chk("t5_ff", 32'(pout_m), 32'h0000_00FF);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with a held word and a half-shifted frame.
    rdy_g = 1'b0;
    send_bits(8'h96, 8, -1, 0);
    send_bits(8'h69, 4, -1, 0);
    chk("t6_pre_cnt4", 32'(cnt_m), 32'h0000_0004);
    chk("t6_pre_vld",  32'(valid_m), 32'h0000_0001);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("t6_async_pout", 32'(pout_m),  32'h0000_0000);
    chk("t6_async_vld",  32'(valid_m), 32'h0000_0000);
    chk("t6_async_cnt",  32'(cnt_m),   32'h0000_0000);
    check_all();
    @(posedge clk); #3 rst = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("t6_ignored", 32'(busy_m), 32'h0000_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom % 2), 1'(($urandom % 4) != 0), 1'(($urandom % 10) == 0),
          1'(($urandom % 5) != 0), 1'(($urandom % 25) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_sipo_framer
